// File: rtl/out_neural_ctrl.sv
`timescale 1ns / 1ps
// out_neural_ctrl: sequences the output layer of the network.
// For each of N_NEURONS neurons it clears the accumulator, streams N_INPUTS
// (hidden output, weight) pairs into the neuron, waits PIPE_LAT cycles for the
// neuron pipeline, then writes the result to the result buffer.
// Optional feature macro: OUT_NEURAL_CTRL_ARGMAX_EN adds a running signed
// argmax over the written results, reported with the done pulse.
module out_neural_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_INPUTS   = 64,
  parameter int unsigned N_NEURONS  = 10,
  parameter int unsigned IN_AW      = 6,
  parameter int unsigned W_AW       = 10,
  parameter int unsigned O_AW       = 4,
  parameter int unsigned PIPE_LAT   = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [IN_AW-1:0]      in_rd_addr,
  input  logic [DATA_WIDTH-1:0] in_rd_data,
  output logic [W_AW-1:0]       w_rd_addr,
  input  logic [DATA_WIDTH-1:0] w_rd_data,
  output logic                  init_mac,
  output logic                  ena_out_input_mac,
  output logic                  ena_out_sigmoid,
  output logic [DATA_WIDTH-1:0] out_neural_input,
  output logic [DATA_WIDTH-1:0] out_neural_weight,
  input  logic [DATA_WIDTH-1:0] out_neural_output,
  output logic                  res_we,
  output logic [O_AW-1:0]       res_addr,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [O_AW-1:0]       class_idx,
  output logic                  class_valid
);

  localparam int unsigned DCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    StIdle, StInit, StFeed, StDrain, StCapture, StFinish
  } state_e;

  state_e                state_q, state_d;
  logic [O_AW-1:0]       n_q;    // current neuron
  logic [IN_AW-1:0]      k_q;    // operand index within the neuron
  logic [W_AW-1:0]       w_q;    // weight address of operand k, runs across neurons
  logic [DCW-1:0]        d_q;    // drain cycle count
  logic [DATA_WIDTH-1:0] in_q, wt_q, res_q;
  logic                  last_feed, last_drain, last_neuron;

  assign last_feed   = (k_q == IN_AW'(N_INPUTS - 1));
  assign last_drain  = (d_q == DCW'(PIPE_LAT - 1));
  assign last_neuron = (n_q == O_AW'(N_NEURONS - 1));
  assign res_addr    = n_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next state and strobes; memory data is forwarded straight to the neuron
  // while feeding and the registered copy holds it afterwards.
  always_comb begin
    state_d           = state_q;
    busy              = 1'b0;
    done              = 1'b0;
    init_mac          = 1'b0;
    ena_out_input_mac = 1'b0;
    ena_out_sigmoid   = 1'b0;
    res_we            = 1'b0;
    in_rd_addr        = k_q;
    w_rd_addr         = w_q;
    out_neural_input  = in_q;
    out_neural_weight = wt_q;
    res_data          = res_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StInit;
      end
      StInit: begin
        busy     = 1'b1;
        init_mac = 1'b1;
        state_d  = StFeed;
      end
      StFeed: begin
        busy              = 1'b1;
        ena_out_input_mac = 1'b1;
        out_neural_input  = in_rd_data;
        out_neural_weight = w_rd_data;
        // Prefetch the next operand, except after the last one
        if (!last_feed) begin
          in_rd_addr = k_q + IN_AW'(1);
          w_rd_addr  = w_q + W_AW'(1);
        end
        if (last_feed) state_d = StDrain;
      end
      StDrain: begin
        busy            = 1'b1;
        ena_out_sigmoid = 1'b1;
        if (last_drain) state_d = StCapture;
      end
      StCapture: begin
        busy     = 1'b1;
        res_we   = 1'b1;
        res_data = out_neural_output;
        state_d  = last_neuron ? StFinish : StInit;
      end
      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counters and operand/result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q   <= '0;
      k_q   <= '0;
      w_q   <= '0;
      d_q   <= '0;
      in_q  <= '0;
      wt_q  <= '0;
      res_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            n_q <= '0;
            k_q <= '0;
            w_q <= '0;
            d_q <= '0;
          end
        end
        StFeed: begin
          in_q <= in_rd_data;
          wt_q <= w_rd_data;
          if (last_feed) begin
            k_q <= '0;
          end else begin
            k_q <= k_q + IN_AW'(1);
            w_q <= w_q + W_AW'(1);
          end
        end
        StDrain: begin
          d_q <= last_drain ? '0 : d_q + DCW'(1);
        end
        StCapture: begin
          res_q <= out_neural_output;
          if (last_neuron) begin
            w_q <= '0;
          end else begin
            n_q <= n_q + O_AW'(1);
            w_q <= w_q + W_AW'(1);  // step to the next neuron's first weight
          end
        end
        default: ;
      endcase
    end
  end

`ifdef OUT_NEURAL_CTRL_ARGMAX_EN
  logic [DATA_WIDTH-1:0] best_val_q;
  logic [O_AW-1:0]       best_idx_q, class_idx_q;
  logic                  take_new;

  // First capture of a run loads unconditionally; ties keep the lower index
  assign take_new = (n_q == '0) || ($signed(out_neural_output) > $signed(best_val_q));

  // Running maximum, published when the run finishes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_val_q  <= '0;
      best_idx_q  <= '0;
      class_idx_q <= '0;
    end else begin
      if (state_q == StCapture && take_new) begin
        best_val_q <= out_neural_output;
        best_idx_q <= n_q;
      end
      if (state_q == StFinish) class_idx_q <= best_idx_q;
    end
  end

  assign class_valid = (state_q == StFinish);
  assign class_idx   = (state_q == StFinish) ? best_idx_q : class_idx_q;
`else
  assign class_valid = 1'b0;
  assign class_idx   = '0;
`endif

endmodule
